lfsr_step_ctrl: RTL and testbench

Input-conditioning and pacing stage placed directly upstream of the 8-bit LFSR random-number core. Turns raw board switches and a push-button into clean, synchronous control for the core: a level `load` with a registered seed, and single-cycle `step` pulses. `step` comes either from a free-running prescaler (run mode) or from debounced button presses (single-step mode). Also keeps a count of steps issued since the last load.

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_step_ctrl_debounce.sv | 32 +++
 rtl/lfsr_step_ctrl.sv | 123 ++++++++++++
 tb/tb_lfsr_step_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types for the LFSR step controller.
// LFSR_STEP_ZERO_GUARD_EN: remap an all-zero seed to 8'h01.
package lfsr_pkg;

    localparam int LFSR_W     = 8;
    localparam int STEP_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

`ifdef LFSR_STEP_ZERO_GUARD_EN
    localparam logic [LFSR_W-1:0] SEED_RST = LFSR_W'(1);

    function automatic logic [LFSR_W-1:0] seed_guard(
        input logic [LFSR_W-1:0] s
    );
        return (s == '0) ? LFSR_W'(1) : s;
    endfunction
`else
    localparam logic [LFSR_W-1:0] SEED_RST = '0;

    function automatic logic [LFSR_W-1:0] seed_guard(
        input logic [LFSR_W-1:0] s
    );
        return s;
    endfunction
`endif

endpackage

// File: rtl/lfsr_step_ctrl_debounce.sv
// Stability-count debouncer for one synchronized input.
// dout follows din after CYCLES consecutive differing samples.
module debounce #(
    parameter int CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count consecutive disagreeing samples; any agreement restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Input conditioning and step pacing for the LFSR core.
// LFSR_STEP_ZERO_GUARD_EN: seed 8'h00 is replaced by 8'h01.
module lfsr_step_ctrl
    import lfsr_pkg::*;
#(
    parameter int PRESCALE        = 500,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  btn_step,
    input  logic                  sw_run,
    input  logic                  sw_load,
    input  logic [LFSR_W-1:0]     sw_seed,
    output logic                  load,
    output logic [LFSR_W-1:0]     seed,
    output logic                  step,
    output logic                  run_led,
    output logic [STEP_CNT_W-1:0] step_count
);

    localparam int RW = LFSR_W + 3;
    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [RW-1:0] s1, s2;
    logic          db_btn, db_run, db_load;
    logic          btn_prev;
    state_t        state, next;
    logic [PW-1:0] presc;
    logic          stay_run, stay_pause;
    logic          term, btn_edge, fire;

    // Two-flop synchronizer on every raw input.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {btn_step, sw_run, sw_load, sw_seed};
            s2 <= s1;
        end
    end

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_btn (
        .clk(clk), .reset(reset),
        .din(s2[LFSR_W+2]), .dout(db_btn)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .reset(reset),
        .din(s2[LFSR_W+1]), .dout(db_run)
    );

    debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .reset(reset),
        .din(s2[LFSR_W]), .dout(db_load)
    );

    // Previous debounced button for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) btn_prev <= 1'b0;
        else       btn_prev <= db_btn;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_LOAD;
        else       state <= next;
    end

    // Next state: load wins, otherwise the run switch picks the mode.
    always_comb begin
        next = state;
        if (db_load) begin
            next = ST_LOAD;
        end else begin
            unique case (state)
                ST_LOAD:  next = db_run ? ST_RUN : ST_PAUSE;
                ST_RUN:   next = db_run ? ST_RUN : ST_PAUSE;
                ST_PAUSE: next = db_run ? ST_RUN : ST_PAUSE;
                default:  next = ST_LOAD;
            endcase
        end
    end

    // A step fires only if no mode change happens in the same cycle.
    always_comb begin
        stay_run   = (state == ST_RUN) && (next == ST_RUN);
        stay_pause = (state == ST_PAUSE) && (next == ST_PAUSE);
        term       = (presc == PLAST);
        btn_edge   = db_btn && !btn_prev;
        fire       = (stay_run && term) || (stay_pause && btn_edge);
    end

    // Registered outputs, prescaler and step counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load       <= 1'b1;
            run_led    <= 1'b0;
            step       <= 1'b0;
            step_count <= '0;
            presc      <= '0;
            seed       <= SEED_RST;
        end else begin
            load    <= (next == ST_LOAD);
            run_led <= (next == ST_RUN);
            step    <= fire;
            if (next == ST_LOAD) begin
                step_count <= '0;
                presc      <= '0;
            end else begin
                if (fire)
                    step_count <= step_count + 1'b1;
                if (stay_run)
                    presc <= term ? '0 : presc + 1'b1;
            end
            if (state == ST_LOAD)
                seed <= seed_guard(s2[LFSR_W-1:0]);
        end
    end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Randomized bench for lfsr_step_ctrl against a behavioural model.
// Honors LFSR_STEP_ZERO_GUARD_EN for expected seed values.
module tb_lfsr_step_ctrl;

    localparam int P = 4;
    localparam int D = 3;
    localparam int ML = 0;
    localparam int MR = 1;
    localparam int MP = 2;

`ifdef LFSR_STEP_ZERO_GUARD_EN
    localparam logic [7:0] SEED0 = 8'h01;
`else
    localparam logic [7:0] SEED0 = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_step = 1'b0;
    logic        sw_run = 1'b0;
    logic        sw_load = 1'b0;
    logic [7:0]  sw_seed = 8'h00;
    logic        load;
    logic [7:0]  seed;
    logic        step;
    logic        run_led;
    logic [15:0] step_count;

    int checks = 0;
    int failures = 0;

    lfsr_step_ctrl #(
        .PRESCALE(P),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_step(btn_step),
        .sw_run(sw_run),
        .sw_load(sw_load),
        .sw_seed(sw_seed),
        .load(load),
        .seed(seed),
        .step(step),
        .run_led(run_led),
        .step_count(step_count)
    );

    always #5 clk = ~clk;

    logic [10:0] hist[$];
    logic [10:0] sh[$];
    logic        m_db[3];
    logic        m_prev;
    int          m_mode;
    int          m_runcyc;
    int          m_cnt;
    logic [7:0]  m_seed;
    logic        m_step;
    logic        m_load;
    logic        m_runled;

    function automatic logic [7:0] guard(input logic [7:0] s);
`ifdef LFSR_STEP_ZERO_GUARD_EN
        return (s == 8'h00) ? 8'h01 : s;
`else
        return s;
`endif
    endfunction

    task automatic m_reset();
        hist.delete();
        hist.push_back(11'd0);
        hist.push_back(11'd0);
        sh.delete();
        for (int b = 0; b < 3; b++) m_db[b] = 1'b0;
        m_prev   = 1'b0;
        m_mode   = ML;
        m_runcyc = 0;
        m_cnt    = 0;
        m_seed   = SEED0;
        m_step   = 1'b0;
        m_load   = 1'b1;
        m_runled = 1'b0;
    endtask

    task automatic m_edge();
        logic [10:0] sp;
        int nx;
        bit all_diff;
        sp = hist[1];
        nx = m_db[2] ? ML : (m_db[1] ? MR : MP);
        m_step = 1'b0;
        if (nx == ML) begin
            m_runcyc = 0;
            m_cnt = 0;
        end else if (m_mode == MR && nx == MR) begin
            m_runcyc++;
            if (m_runcyc % P == 0) m_step = 1'b1;
        end else if (m_mode == MP && nx == MP && m_db[0] && !m_prev) begin
            m_step = 1'b1;
        end
        if (m_step) m_cnt = (m_cnt + 1) % 65536;
        if (m_mode == ML) m_seed = guard(sp[7:0]);
        m_prev = m_db[0];
        sh.push_back(sp);
        if (sh.size() > D) void'(sh.pop_front());
        for (int b = 0; b < 3; b++) begin
            if (sh.size() == D) begin
                all_diff = 1'b1;
                foreach (sh[i])
                    if (sh[i][10-b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) m_db[b] = ~m_db[b];
            end
        end
        hist.push_front({btn_step, sw_run, sw_load, sw_seed});
        void'(hist.pop_back());
        m_mode   = nx;
        m_load   = (nx == ML);
        m_runled = (nx == MR);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic cmp_all();
        chk("load", int'(load), int'(m_load));
        chk("run_led", int'(run_led), int'(m_runled));
        chk("step", int'(step), int'(m_step));
        chk("step_count", int'(step_count), m_cnt);
        chk("seed", int'(seed), int'(m_seed));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) m_reset();
        else       m_edge();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1 m_reset();
        cmp_all();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_run(input logic v, input int lim, input string nm);
        int n = 0;
        while (run_led !== v && n < lim) begin
            tick();
            n++;
        end
        chk(nm, int'(run_led), int'(v));
    endtask

    task automatic wait_load(input logic v, input int lim, input string nm);
        int n = 0;
        while (load !== v && n < lim) begin
            tick();
            n++;
        end
        chk(nm, int'(load), int'(v));
    endtask

    int ns;
    int d;
    logic pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        m_reset();
        tick();
        tick();
        chk("rst_load", int'(load), 1);
        chk("rst_run_led", int'(run_led), 0);
        chk("rst_count", int'(step_count), 0);
        chk("rst_seed", int'(seed), int'(SEED0));
        reset = 1'b0;
        repeat (6) tick();
        chk("pause_load", int'(load), 0);
        chk("pause_run_led", int'(run_led), 0);

        ns = 0;
        foreach (pat[i]) begin
            btn_step = pat[i];
            tick();
            if (step) ns++;
        end
        repeat (50) begin
            tick();
            if (step) ns++;
        end
        btn_step = 1'b0;
        repeat (10) begin
            tick();
            if (step) ns++;
        end
        chk("btn_pulses", ns, 1);
        chk("btn_count", int'(step_count), 1);

        ns = 0;
        btn_step = 1'b1;
        repeat (2) begin
            tick();
            if (step) ns++;
        end
        btn_step = 1'b0;
        repeat (10) begin
            tick();
            if (step) ns++;
        end
        chk("short_press", ns, 0);

        sw_load = 1'b1;
        sw_seed = 8'hA5;
        repeat (10) tick();
        chk("seed_load", int'(load), 1);
        chk("seed_a5", int'(seed), 8'hA5);
        chk("seed_cnt0", int'(step_count), 0);
        sw_run  = 1'b1;
        sw_load = 1'b0;
        wait_run(1'b1, 20, "run_enter");
        ns = 0;
        repeat (20) begin
            tick();
            if (step) ns++;
        end
        chk("run_pulses", ns, 5);
        chk("run_count", int'(step_count), 5);
        chk("run_seed_hold", int'(seed), 8'hA5);

        d = 0;
        while (!step && d < 3 * P) begin
            tick();
            d++;
        end
        chk("run_step_seen", int'(step), 1);
        tick();
        sw_run = 1'b0;
        wait_run(1'b0, 20, "run_exit");
        ns = 0;
        repeat (30) begin
            tick();
            if (step) ns++;
        end
        chk("paused_pulses", ns, 0);
        sw_run = 1'b1;
        wait_run(1'b1, 20, "run_resume");
        d = 0;
        while (!step && d < 20) begin
            tick();
            d++;
        end
        chk("resume_gap", d, 2);

        sw_load = 1'b1;
        wait_load(1'b1, 20, "load_enter");
        ns = 0;
        repeat (10) begin
            tick();
            if (step) ns++;
        end
        chk("load_pulses", ns, 0);
        chk("load_count", int'(step_count), 0);
        sw_seed = 8'h3C;
        repeat (5) tick();
        chk("seed_3c", int'(seed), 8'h3C);
        sw_seed = 8'h7E;
        repeat (5) tick();
        chk("seed_7e", int'(seed), 8'h7E);
        sw_seed = 8'h00;
        repeat (5) tick();
        chk("seed_zero", int'(seed), int'(SEED0));
        sw_load = 1'b0;

        repeat (3000) begin
            if ($urandom_range(0, 19) == 0) btn_step = ~btn_step;
            if ($urandom_range(0, 79) == 0) sw_run = ~sw_run;
            if ($urandom_range(0, 199) == 0) sw_load = ~sw_load;
            if ($urandom_range(0, 7) == 0) sw_seed = 8'($urandom);
            if ($urandom_range(0, 699) == 0) async_reset();
            else tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
